// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: write port, two read ports, clear request and status.
// The master drives addresses, data and requests; the slave returns read data and status.
interface param_reg_file_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] IN;
   logic [AW-1:0]    INADDRESS;
   logic             WRITE;
   logic [AW-1:0]    OUT1ADDRESS;
   logic [AW-1:0]    OUT2ADDRESS;
   logic             CLEAR;
   logic [WIDTH-1:0] OUT1;
   logic [WIDTH-1:0] OUT2;
   logic             BUSY;
   logic             WERR;

   modport master (
      output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
      input  OUT1, OUT2, BUSY, WERR
   );

   modport slave (
      input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
      output OUT1, OUT2, BUSY, WERR
   );
endinterface

// File: rtl/param_reg_file.sv
// WIDTH x DEPTH register file: one write port, two registered read ports with write-through
// bypass, optional hardwired-zero entry 0, and a one-entry-per-cycle bulk-clear engine.
module param_reg_file #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter bit ZERO_REG = 1'b0
) (
   input logic             CLK,
   input logic             RESET,
   param_reg_file_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      CLEARING = 1'b1
   } state_e;

   state_e           stateQ, stateD;
   logic [AW-1:0]    cntQ, cntD;
   logic [WIDTH-1:0] memQ [DEPTH];
   logic [WIDTH-1:0] out1Q, out1D;
   logic [WIDTH-1:0] out2Q, out2D;
   logic             werrQ, werrD;

   logic busy;
   logic zeroTarget;
   logic writeEn;
   logic clearEn;

   assign busy       = (stateQ == CLEARING);
   assign zeroTarget = ZERO_REG && (bus.INADDRESS == '0);
   assign writeEn    = bus.WRITE && !busy && !zeroTarget;
   assign clearEn    = busy;

   // Value the addressed entry holds after this edge, so read data never lags a same-edge update.
   function automatic logic [WIDTH-1:0] postEdgeValue(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] value;
      value = memQ[addr];
      if (ZERO_REG && (addr == '0)) begin
         value = '0;
      end else if (clearEn && (addr == cntQ)) begin
         value = '0;
      end else if (writeEn && (addr == bus.INADDRESS)) begin
         value = bus.IN;
      end
      return value;
   endfunction

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         IDLE: begin
            if (bus.CLEAR) begin
               stateD = CLEARING;
               cntD   = '0;
            end
         end
         CLEARING: begin
            cntD = cntQ + 1'b1;
            if (cntQ == AW'(DEPTH - 1)) begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
            cntD   = '0;
         end
      endcase
   end

   always_comb begin
      out1D = postEdgeValue(bus.OUT1ADDRESS);
      out2D = postEdgeValue(bus.OUT2ADDRESS);
      werrD = bus.WRITE && busy;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stateQ <= IDLE;
         cntQ   <= '0;
         out1Q  <= '0;
         out2Q  <= '0;
         werrQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         out1Q  <= out1D;
         out2Q  <= out2D;
         werrQ  <= werrD;
      end
   end

   // Writes are only accepted while idle, so a clear and a write never target the array together.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            memQ[i] <= '0;
         end
      end else if (clearEn) begin
         memQ[cntQ] <= '0;
      end else if (writeEn) begin
         memQ[bus.INADDRESS] <= bus.IN;
      end
   end

   assign bus.OUT1 = out1Q;
   assign bus.OUT2 = out2Q;
   assign bus.BUSY = busy;
   assign bus.WERR = werrQ;
endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: one instance with ZERO_REG=0 and one with ZERO_REG=1,
// expectations queued when stimulus is driven and checked one cycle later.
module tb_param_reg_file;
   localparam int W = 8;
   localparam int D = 8;

   typedef struct {
      logic [7:0] o1;
      logic [7:0] o2;
      logic       busy;
      logic       werr;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;

   exp_t expQ[$];
   int   errors = 0;
   int   checks = 0;

   logic [7:0] refMem [8];
   logic       refBusy;
   logic [2:0] refCnt;

   always #5 CLK = ~CLK;

   param_reg_file_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
   param_reg_file_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

   param_reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) dut0 (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus0.slave)
   );

   param_reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) dut1 (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus1.slave)
   );

   // Drives one cycle on dut0, advances the reference model and queues the expected outputs.
   task automatic step(input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a1, input logic [2:0] a2, input logic clr);
      exp_t e;
      bus0.WRITE       = wr;
      bus0.INADDRESS   = wa;
      bus0.IN          = wd;
      bus0.OUT1ADDRESS = a1;
      bus0.OUT2ADDRESS = a2;
      bus0.CLEAR       = clr;
      e.werr = wr && refBusy;
      if (refBusy) refMem[refCnt] = 8'd0;
      else if (wr) refMem[wa] = wd;
      e.o1 = refMem[a1];
      e.o2 = refMem[a2];
      if (refBusy) begin
         if (refCnt == 3'd7) refBusy = 1'b0;
         refCnt = refCnt + 3'd1;
      end else if (clr) begin
         refBusy = 1'b1;
         refCnt  = 3'd0;
      end
      e.busy = refBusy;
      expQ.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      bus0.WRITE = 0; bus0.INADDRESS = 0; bus0.IN = 0; bus0.OUT1ADDRESS = 0; bus0.OUT2ADDRESS = 0; bus0.CLEAR = 0;
      bus1.WRITE = 0; bus1.INADDRESS = 0; bus1.IN = 0; bus1.OUT1ADDRESS = 0; bus1.OUT2ADDRESS = 0; bus1.CLEAR = 0;
      for (int i = 0; i < 8; i++) refMem[i] = 8'd0;
      refBusy = 1'b0;
      refCnt  = 3'd0;
      RESET = 1'b1;
      #3 RESET = 1'b0;
      #1;
      checks++; if (bus0.OUT1 !== 8'd0) begin errors++; $display("[TB] FAIL reset.out1 got=%0h exp=0", bus0.OUT1); end
      checks++; if (bus0.OUT2 !== 8'd0) begin errors++; $display("[TB] FAIL reset.out2 got=%0h exp=0", bus0.OUT2); end
      checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got=%b exp=0", bus0.BUSY); end
      checks++; if (bus0.WERR !== 1'b0) begin errors++; $display("[TB] FAIL reset.werr got=%b exp=0", bus0.WERR); end
      checks++; if (bus1.OUT1 !== 8'd0 || bus1.BUSY !== 1'b0) begin
         errors++; $display("[TB] FAIL reset.dut1 out1=%0h busy=%b exp=0/0", bus1.OUT1, bus1.BUSY);
      end
      @(posedge CLK);
      @(posedge CLK);
      #2 RESET = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(0, 3'd0, 8'd0, 3'(i), 3'(7 - i), 0);
         e = expQ.pop_front();
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL reset_read.out1[%0d] got=%0h exp=%0h", i, bus0.OUT1, e.o1); end
         checks++; if (bus0.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL reset_read.out2[%0d] got=%0h exp=%0h", i, bus0.OUT2, e.o2); end
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       step(1, 3'd3, 8'd115, 3'd3, 3'd0, 0);
            1:       step(1, 3'd0, 8'd58,  3'd1, 3'd2, 0);
            default: step(0, 3'd0, 8'd0,   3'd0, 3'd3, 0);
         endcase
         e = expQ.pop_front();
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL write_read.out1[%0d] got=%0d exp=%0d", i, bus0.OUT1, e.o1); end
         checks++; if (bus0.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL write_read.out2[%0d] got=%0d exp=%0d", i, bus0.OUT2, e.o2); end
         checks++; if (bus0.WERR !== e.werr) begin errors++; $display("[TB] FAIL write_read.werr[%0d] got=%b exp=%b", i, bus0.WERR, e.werr); end
      end
   endtask

   task automatic test_dual_port();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) step(1, 3'd5, 8'hA5, 3'd0, 3'd0, 0);
         else        step(0, 3'd0, 8'h00, 3'd5, 3'd5, 0);
         e = expQ.pop_front();
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL dual_port.out1[%0d] got=%0h exp=%0h", i, bus0.OUT1, e.o1); end
         checks++; if (bus0.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL dual_port.out2[%0d] got=%0h exp=%0h", i, bus0.OUT2, e.o2); end
      end
   endtask

   task automatic test_bulk_clear();
      exp_t e;
      int   busyCycles;
      busyCycles = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 3'(i), 8'(i + 1), 3'(i), 3'(i), 0);
         e = expQ.pop_front();
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL preload.out1[%0d] got=%0d exp=%0d", i, bus0.OUT1, e.o1); end
      end
      // k = -1 is the CLEAR edge E0; CLEAR is reissued at k = 2 while already clearing.
      for (int k = -1; k < 12; k++) begin
         step(0, 3'd0, 8'd0, 3'd7, 3'(k), (k == -1) || (k == 2));
         e = expQ.pop_front();
         if (bus0.BUSY === 1'b1) busyCycles++;
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL clear.out1[%0d] got=%0d exp=%0d", k, bus0.OUT1, e.o1); end
         checks++; if (bus0.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL clear.out2[%0d] got=%0d exp=%0d", k, bus0.OUT2, e.o2); end
         checks++; if (bus0.BUSY !== e.busy) begin errors++; $display("[TB] FAIL clear.busy[%0d] got=%b exp=%b", k, bus0.BUSY, e.busy); end
      end
      checks++; if (busyCycles != 8) begin errors++; $display("[TB] FAIL clear.busy_cycles got=%0d exp=8", busyCycles); end
   endtask

   task automatic test_dropped_write();
      exp_t e;
      int   n;
      for (n = 0; n < 20; n++) begin
         case (n)
            0:       step(0, 3'd0, 8'd0,  3'd2, 3'd2, 1);
            1, 2:    step(1, 3'd2, 8'd35, 3'd2, 3'd3, 0);
            3:       step(0, 3'd0, 8'd0,  3'd2, 3'd2, 0);
            10:      step(1, 3'd4, 8'd99, 3'd4, 3'd4, 1);
            default: step(0, 3'd0, 8'd0,  3'd4, 3'd2, 0);
         endcase
         e = expQ.pop_front();
         checks++; if (bus0.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL dropped.out1[%0d] got=%0d exp=%0d", n, bus0.OUT1, e.o1); end
         checks++; if (bus0.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL dropped.out2[%0d] got=%0d exp=%0d", n, bus0.OUT2, e.o2); end
         checks++; if (bus0.BUSY !== e.busy) begin errors++; $display("[TB] FAIL dropped.busy[%0d] got=%b exp=%b", n, bus0.BUSY, e.busy); end
         checks++; if (bus0.WERR !== e.werr) begin errors++; $display("[TB] FAIL dropped.werr[%0d] got=%b exp=%b", n, bus0.WERR, e.werr); end
      end
   endtask

   task automatic test_zero_reg();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         bus1.WRITE       = (i < 2);
         bus1.INADDRESS   = (i == 0) ? 3'd6 : 3'd0;
         bus1.IN          = 8'd50;
         bus1.OUT1ADDRESS = (i < 3) ? 3'd0 : 3'd6;
         bus1.OUT2ADDRESS = 3'd6;
         bus1.CLEAR       = (i == 3);
         e.o1   = (i < 3) ? 8'd0 : 8'd50;
         e.o2   = 8'd50;
         e.busy = (i >= 3);
         e.werr = 1'b0;
         expQ.push_back(e);
         @(posedge CLK);
         #1;
         e = expQ.pop_front();
         checks++; if (bus1.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL zero_reg.out1[%0d] got=%0d exp=%0d", i, bus1.OUT1, e.o1); end
         checks++; if (bus1.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL zero_reg.out2[%0d] got=%0d exp=%0d", i, bus1.OUT2, e.o2); end
         checks++; if (bus1.BUSY !== e.busy) begin errors++; $display("[TB] FAIL zero_reg.busy[%0d] got=%b exp=%b", i, bus1.BUSY, e.busy); end
         checks++; if (bus1.WERR !== e.werr) begin errors++; $display("[TB] FAIL zero_reg.werr[%0d] got=%b exp=%b", i, bus1.WERR, e.werr); end
      end
      #2 RESET = 1'b0;
      #1;
      checks++; if (bus1.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midclear_reset.busy got=%b exp=0", bus1.BUSY); end
      checks++; if (bus1.OUT1 !== 8'd0) begin errors++; $display("[TB] FAIL midclear_reset.out1 got=%0d exp=0", bus1.OUT1); end
      bus1.WRITE = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus1.OUT1ADDRESS = 3'(i);
         bus1.OUT2ADDRESS = 3'd6;
         e.o1 = 8'd0; e.o2 = 8'd0; e.busy = 1'b0; e.werr = 1'b0;
         expQ.push_back(e);
         @(posedge CLK);
         #1;
         e = expQ.pop_front();
         checks++; if (bus1.OUT1 !== e.o1) begin errors++; $display("[TB] FAIL post_reset.out1[%0d] got=%0d exp=%0d", i, bus1.OUT1, e.o1); end
         checks++; if (bus1.OUT2 !== e.o2) begin errors++; $display("[TB] FAIL post_reset.out2[%0d] got=%0d exp=%0d", i, bus1.OUT2, e.o2); end
         checks++; if (bus1.BUSY !== e.busy) begin errors++; $display("[TB] FAIL post_reset.busy[%0d] got=%b exp=%b", i, bus1.BUSY, e.busy); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_dual_port();
      test_bulk_clear();
      test_dropped_write();
      test_zero_reg();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end
endmodule
